trigger_link_sequencer: RTL and testbench

Startup and recovery sequencer for the four GTX trigger transmit links (CSC right/left, GEM right/left). It drives the TX PLL reset, the GTX TX reset and the trigger datapath reset in order. It waits for PLL lock and TX reset/sync completion, retrying on timeout. It then holds the links up, restarts automatically on loss of lock, and exposes status and saturating counters for slow control.

---
 rtl/trigger_link_sequencer.sv | 141 ++++++++++++++
 tb/tb_trigger_link_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_link_sequencer.sv
// rtl/trigger_link_sequencer.sv - startup/recovery sequencer for the four GTX trigger TX links
module trigger_link_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned GTX_RST_CYCLES = 8,
  parameter int unsigned DONE_TIMEOUT   = 8192,
  parameter int unsigned LOSS_FILTER    = 4
) (
  input  logic       clk_40,
  input  logic       reset_n,
  input  logic       restart,
  input  logic [3:0] link_mask,
  input  logic [3:0] tx_pll_locked,
  input  logic [3:0] tx_resetdone,
  input  logic [3:0] tx_sync_done,
  output logic       txpll_rst,
  output logic       gtx_reset,
  output logic       trg_rst,
  output logic       links_ready,
  output logic [2:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_GTX_RST   = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_LINK_UP   = 3'd4;

  localparam logic [15:0] PLL_LAST  = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] GTX_LAST  = 16'(GTX_RST_CYCLES - 1);
  localparam logic [15:0] DONE_LAST = 16'(DONE_TIMEOUT - 1);
  localparam logic [7:0]  LOSS_LAST = 8'(LOSS_FILTER - 1);

  logic [3:0] lock_m, lock_s, rd_m, rd_s, sd_m, sd_s;
  logic       all_locked, all_done;
  logic [15:0] timer;
  logic [7:0]  filter;
  logic [2:0]  state_nxt;
  logic        retry_inc, loss_inc, reenter;

  always_ff @(posedge clk_40 or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 4'd0;
      lock_s <= 4'd0;
      rd_m   <= 4'd0;
      rd_s   <= 4'd0;
      sd_m   <= 4'd0;
      sd_s   <= 4'd0;
    end else begin
      lock_m <= tx_pll_locked;
      lock_s <= lock_m;
      rd_m   <= tx_resetdone;
      rd_s   <= rd_m;
      sd_m   <= tx_sync_done;
      sd_s   <= sd_m;
    end
  end

  // Masked links count as good so a fully masked bundle passes every check.
  assign all_locked = &(lock_s | link_mask);
  assign all_done   = &((rd_s & sd_s) | link_mask);

  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (restart) begin
      state_nxt = S_PLL_RST;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (timer == PLL_LAST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (all_locked) begin
            state_nxt = S_GTX_RST;
          end else if (timer == LOCK_LAST) begin
            state_nxt = S_PLL_RST;
            retry_inc = 1'b1;
          end
        end
        S_GTX_RST: begin
          if (!all_locked) state_nxt = S_PLL_RST;
          else if (timer == GTX_LAST) state_nxt = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (all_done) begin
            state_nxt = S_LINK_UP;
          end else if (timer == DONE_LAST) begin
            state_nxt = S_GTX_RST;
            retry_inc = 1'b1;
          end
        end
        S_LINK_UP: begin
          if (!all_locked && filter == LOSS_LAST) begin
            state_nxt = S_PLL_RST;
            loss_inc  = 1'b1;
          end
        end
        default: state_nxt = S_PLL_RST;
      endcase
    end
  end

  // A restart counts as a fresh entry even when already in PLL_RST.
  assign reenter = restart || (state_nxt != state);

  always_ff @(posedge clk_40 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_PLL_RST;
      timer       <= 16'd0;
      filter      <= 8'd0;
      retry_cnt   <= 8'd0;
      loss_cnt    <= 8'd0;
      txpll_rst   <= 1'b1;
      gtx_reset   <= 1'b1;
      trg_rst     <= 1'b1;
      links_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      if (reenter) timer <= 16'd0;
      else if (timer != 16'hFFFF) timer <= timer + 16'd1;
      if (reenter || all_locked) filter <= 8'd0;
      else if (state == S_LINK_UP && filter != 8'hFF) filter <= filter + 8'd1;
      if (retry_inc && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
      if (loss_inc && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
      // Decoding the next state keeps the outputs aligned with the state register.
      case (state_nxt)
        S_WAIT_LOCK: {txpll_rst, gtx_reset, trg_rst, links_ready} <= 4'b0110;
        S_GTX_RST:   {txpll_rst, gtx_reset, trg_rst, links_ready} <= 4'b0110;
        S_WAIT_DONE: {txpll_rst, gtx_reset, trg_rst, links_ready} <= 4'b0010;
        S_LINK_UP:   {txpll_rst, gtx_reset, trg_rst, links_ready} <= 4'b0001;
        default:     {txpll_rst, gtx_reset, trg_rst, links_ready} <= 4'b1110;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_link_sequencer.sv
// tb/tb_trigger_link_sequencer.sv - self-checking bench for trigger_link_sequencer
module tb_trigger_link_sequencer;

  logic       clk_40 = 1'b0;
  logic       reset_n;
  logic       restart;
  logic [3:0] link_mask;
  logic [3:0] tx_pll_locked;
  logic [3:0] done_in;
  logic       txpll_rst, gtx_reset, trg_rst, links_ready;
  logic [2:0] state;
  logic [7:0] retry_cnt, loss_cnt;
  logic [3:0] ctl;

  always #12 clk_40 = ~clk_40;
  assign ctl = {txpll_rst, gtx_reset, trg_rst, links_ready};

  trigger_link_sequencer #(
    .PLL_RST_CYCLES(16),
    .LOCK_TIMEOUT(64),
    .GTX_RST_CYCLES(8),
    .DONE_TIMEOUT(256),
    .LOSS_FILTER(4)
  ) dut (
    .clk_40(clk_40),
    .reset_n(reset_n),
    .restart(restart),
    .link_mask(link_mask),
    .tx_pll_locked(tx_pll_locked),
    .tx_resetdone(done_in),
    .tx_sync_done(done_in),
    .txpll_rst(txpll_rst),
    .gtx_reset(gtx_reset),
    .trg_rst(trg_rst),
    .links_ready(links_ready),
    .state(state),
    .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt)
  );

  typedef struct {
    int         at;
    logic [3:0] lock;
    logic [3:0] done;
    logic [2:0] st;
    logic [3:0] ctl;
    logic [7:0] retry;
    logic [7:0] loss;
  } vec_t;

  typedef struct {
    int         due;
    string      name;
    logic [2:0] st;
    logic [3:0] ctl;
    logic [7:0] retry;
    logic [7:0] loss;
  } exp_t;

  exp_t sb[$];
  vec_t nom[12];
  int   cyc;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_exp(input int due, input string name, input logic [2:0] st,
                          input logic [3:0] c, input logic [7:0] r, input logic [7:0] l);
    exp_t e;
    e.due = due; e.name = name; e.st = st; e.ctl = c; e.retry = r; e.loss = l;
    sb.push_back(e);
  endtask

  task automatic compare_due();
    exp_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk({e.name, "_state"}, {5'd0, state}, {5'd0, e.st});
      chk({e.name, "_ctl"}, {4'd0, ctl}, {4'd0, e.ctl});
      chk({e.name, "_retry"}, retry_cnt, e.retry);
      chk({e.name, "_loss"}, loss_cnt, e.loss);
    end
  endtask

  task automatic step();
    @(posedge clk_40);
    #1;
    cyc++;
    compare_due();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int n = 0;
    while (state !== target && n < budget) begin
      step();
      n++;
    end
    chk(name, {5'd0, state}, {5'd0, target});
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int c;
    int e;
    int e2;
    reset_n = 1'b0;
    restart = 1'b0;
    link_mask = 4'h0;
    tx_pll_locked = 4'h0;
    done_in = 4'h0;
    cyc = 0;

    #30;
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_ctl", {4'd0, ctl}, 8'b1110);
    chk("rst_retry", retry_cnt, 8'd0);
    chk("rst_loss", loss_cnt, 8'd0);

    // Nominal bring-up: locks at cycle 40, done at cycle 60.
    nom[0]  = '{0,  4'h0, 4'h0, 3'd0, 4'b1110, 8'd0, 8'd0};
    nom[1]  = '{15, 4'h0, 4'h0, 3'd0, 4'b1110, 8'd0, 8'd0};
    nom[2]  = '{16, 4'h0, 4'h0, 3'd1, 4'b0110, 8'd0, 8'd0};
    nom[3]  = '{40, 4'hF, 4'h0, 3'd1, 4'b0110, 8'd0, 8'd0};
    nom[4]  = '{42, 4'hF, 4'h0, 3'd1, 4'b0110, 8'd0, 8'd0};
    nom[5]  = '{43, 4'hF, 4'h0, 3'd2, 4'b0110, 8'd0, 8'd0};
    nom[6]  = '{50, 4'hF, 4'h0, 3'd2, 4'b0110, 8'd0, 8'd0};
    nom[7]  = '{51, 4'hF, 4'h0, 3'd3, 4'b0010, 8'd0, 8'd0};
    nom[8]  = '{60, 4'hF, 4'hF, 3'd3, 4'b0010, 8'd0, 8'd0};
    nom[9]  = '{62, 4'hF, 4'hF, 3'd3, 4'b0010, 8'd0, 8'd0};
    nom[10] = '{63, 4'hF, 4'hF, 3'd4, 4'b0001, 8'd0, 8'd0};
    nom[11] = '{70, 4'hF, 4'hF, 3'd4, 4'b0001, 8'd0, 8'd0};
    foreach (nom[i]) push_exp(nom[i].at, $sformatf("nom%0d", i), nom[i].st, nom[i].ctl,
                              nom[i].retry, nom[i].loss);

    @(posedge clk_40);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    compare_due();
    for (int i = 0; i < 12; i++) begin
      run_to(nom[i].at);
      tx_pll_locked = nom[i].lock;
      done_in = nom[i].done;
    end

    // Lock 1 low for 3 cycles: filter must not trip.
    tx_pll_locked = 4'b1101;
    repeat (3) step();
    tx_pll_locked = 4'hF;
    repeat (6) step();
    chk("loss3_state", {5'd0, state}, 8'd4);
    chk("loss3_cnt", loss_cnt, 8'd0);

    // Done/sync dropping in LINK_UP is ignored.
    done_in = 4'h0;
    repeat (8) step();
    chk("done_drop_state", {5'd0, state}, 8'd4);
    done_in = 4'hF;

    // Lock 1 low for 4 cycles: exit to PLL_RST with loss_cnt=1.
    c = cyc;
    tx_pll_locked = 4'b1101;
    push_exp(c + 5, "loss4_pre", 3'd4, 4'b0001, 8'd0, 8'd0);
    push_exp(c + 6, "loss4_exit", 3'd0, 4'b1110, 8'd0, 8'd1);
    repeat (4) step();
    tx_pll_locked = 4'hF;
    repeat (2) step();
    wait_state(3'd4, 100, "rebringup");

    // Link 3 masked with its status held low.
    link_mask = 4'b1000;
    tx_pll_locked = 4'b0111;
    done_in = 4'b0111;
    pulse_restart();
    chk("mask_restart_state", {5'd0, state}, 8'd0);
    chk("mask_restart_loss", loss_cnt, 8'd1);
    wait_state(3'd4, 100, "mask_linkup");
    repeat (8) step();
    for (int k = 0; k < 12; k++) begin
      tx_pll_locked[3] = ~tx_pll_locked[3];
      step();
    end
    repeat (4) step();
    chk("mask_toggle_state", {5'd0, state}, 8'd4);
    chk("mask_toggle_loss", loss_cnt, 8'd1);

    // Restart on the same cycle as a loss event.
    tx_pll_locked = 4'hF;
    done_in = 4'hF;
    repeat (3) step();
    link_mask = 4'h0;
    step();
    chk("unmask_state", {5'd0, state}, 8'd4);
    c = cyc;
    tx_pll_locked = 4'b1101;
    push_exp(c + 5, "rst_loss_pre", 3'd4, 4'b0001, 8'd0, 8'd1);
    push_exp(c + 6, "rst_loss", 3'd0, 4'b1110, 8'd0, 8'd1);
    repeat (4) step();
    tx_pll_locked = 4'hF;
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;

    // Done timeout, then done arriving exactly on the timeout cycle.
    done_in = 4'h0;
    wait_state(3'd3, 100, "wd_entry");
    e = cyc;
    e2 = e + 264;
    push_exp(e + 255, "wd_pre_to", 3'd3, 4'b0010, 8'd0, 8'd1);
    push_exp(e + 256, "wd_timeout", 3'd2, 4'b0110, 8'd1, 8'd1);
    push_exp(e2, "wd_reentry", 3'd3, 4'b0010, 8'd1, 8'd1);
    push_exp(e2 + 255, "wd_sim_pre", 3'd3, 4'b0010, 8'd1, 8'd1);
    push_exp(e2 + 256, "wd_sim_done", 3'd4, 4'b0001, 8'd1, 8'd1);
    run_to(e2 + 253);
    done_in = 4'hF;
    run_to(e2 + 256);

    // Asynchronous reset while in WAIT_DONE.
    done_in = 4'h0;
    pulse_restart();
    wait_state(3'd3, 100, "mid_wd_entry");
    repeat (5) step();
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", {5'd0, state}, 8'd0);
    chk("mid_rst_ctl", {4'd0, ctl}, 8'b1110);
    chk("mid_rst_retry", retry_cnt, 8'd0);
    chk("mid_rst_loss", loss_cnt, 8'd0);

    // Lock 0 held low: retry every 80 cycles, saturating at 255.
    tx_pll_locked = 4'b1110;
    @(posedge clk_40);
    @(posedge clk_40);
    #1;
    cyc = 0;
    push_exp(15, "rel_pll_hold", 3'd0, 4'b1110, 8'd0, 8'd0);
    push_exp(16, "rel_wait_lock", 3'd1, 4'b0110, 8'd0, 8'd0);
    push_exp(79, "lto_pre", 3'd1, 4'b0110, 8'd0, 8'd0);
    push_exp(80, "lto_1", 3'd0, 4'b1110, 8'd1, 8'd0);
    push_exp(160, "lto_2", 3'd0, 4'b1110, 8'd2, 8'd0);
    push_exp(240, "lto_3", 3'd0, 4'b1110, 8'd3, 8'd0);
    push_exp(20320, "lto_254", 3'd0, 4'b1110, 8'd254, 8'd0);
    push_exp(20400, "lto_255", 3'd0, 4'b1110, 8'd255, 8'd0);
    push_exp(20480, "lto_sat", 3'd0, 4'b1110, 8'd255, 8'd0);
    reset_n = 1'b1;
    run_to(20480);

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
